// File: rtl/vga_pkg.sv
// Shared raster, framebuffer and pixel-format constants for the 640x480 VGA path.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_W   = H_ACTIVE / 2;
  localparam int FB_H   = V_ACTIVE / 2;
  localparam int ADDR_W = 17;

  // RGB332 field positions within a framebuffer byte
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Widen each field by replicating its MSBs so full-scale stays full-scale.
  function automatic rgb12_t expand_rgb332(input logic [7:0] d);
    rgb12_t c;
    c.r = {d[R_MSB:R_LSB], d[R_MSB]};
    c.g = {d[G_MSB:G_LSB], d[G_MSB]};
    c.b = {d[B_MSB:B_LSB], d[B_MSB:B_LSB]};
    return c;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a configurable reset value, used to align
// sync and blank with the framebuffer read pipeline.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch for a 640x480 raster: 2x-doubled 320x240 RGB332 source,
// expanded to 12-bit RGB with syncs delayed to line up with the pixel data.
module vga_pixel_fetch #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int FB_W     = H_ACTIVE / 2,
  parameter int ADDR_W   = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              hblank,
  input  logic              vblank,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  input  logic [7:0]        fb_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vblank_start
);
  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic              active;
  logic              hblank_rise;
  logic              blank_in;
  logic              blank_dly;
  logic [1:0]        sync_dly;
  logic              hblank_q;
  logic              vblank_q;
  logic              frame_ok_q;
  logic              fb_rd_en_q;
  logic              vblank_start_q;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] pix_addr_q,  pix_addr_d;
  logic [ADDR_W-1:0] fb_addr_q,   fb_addr_d;
  rgb12_t            rgb_q,       rgb_d;
  logic              unused_cnt_bits;

  assign active      = ~hblank & ~vblank;
  assign hblank_rise = hblank & ~hblank_q;
  assign unused_cnt_bits = ^{hcount[9:1], vcount[9:1]};

  // Vertical blank wins over the end-of-line update, so every frame starts at 0.
  always_comb begin
    line_base_d = line_base_q;
    pix_addr_d  = pix_addr_q;
    if (vblank) begin
      line_base_d = '0;
      pix_addr_d  = '0;
    end else if (hblank_rise) begin
      if (vcount[0]) begin
        line_base_d = line_base_q + LINE_STEP;
        pix_addr_d  = line_base_q + LINE_STEP;
      end else begin
        pix_addr_d  = line_base_q;
      end
    end else if (active && hcount[0]) begin
      pix_addr_d = pix_addr_q + ADDR_ONE;
    end
  end

  assign fb_addr_d = active ? pix_addr_q : fb_addr_q;

  // Until a vblank has realigned the address counters after reset, output stays black.
  assign blank_in = hblank | vblank | ~frame_ok_q;

  always_comb begin
    rgb_d = '0;
    if (!blank_dly) begin
      rgb_d = expand_rgb332(fb_data);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hblank_q       <= 1'b1;
      vblank_q       <= 1'b1;
      frame_ok_q     <= 1'b0;
      line_base_q    <= '0;
      pix_addr_q     <= '0;
      fb_addr_q      <= '0;
      fb_rd_en_q     <= 1'b0;
      vblank_start_q <= 1'b0;
      rgb_q          <= '0;
    end else begin
      hblank_q       <= hblank;
      vblank_q       <= vblank;
      frame_ok_q     <= frame_ok_q | vblank;
      line_base_q    <= line_base_d;
      pix_addr_q     <= pix_addr_d;
      fb_addr_q      <= fb_addr_d;
      fb_rd_en_q     <= active;
      vblank_start_q <= vblank & ~vblank_q;
      rgb_q          <= rgb_d;
    end
  end

  // Syncs take three stages to land with the RGB register; blank takes two
  // because the RGB register itself is the third.
  vga_delay_line #(
    .WIDTH     (2),
    .DEPTH     (3),
    .RESET_VAL (2'b11)
  ) u_sync_dly (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    ({hsync, vsync}),
    .q_o    (sync_dly)
  );

  vga_delay_line #(
    .WIDTH     (1),
    .DEPTH     (2),
    .RESET_VAL (1'b1)
  ) u_blank_dly (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (blank_in),
    .q_o    (blank_dly)
  );

  assign fb_addr      = fb_addr_q;
  assign fb_rd_en     = fb_rd_en_q;
  assign vga_r        = rgb_q.r;
  assign vga_g        = rgb_q.g;
  assign vga_b        = rgb_q.b;
  assign vga_hsync    = sync_dly[1];
  assign vga_vsync    = sync_dly[0];
  assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch driven by a compressed raster: full-width
// lines at the frame edges, short lines in between, to keep frames small.
module tb_vga_pixel_fetch;

  localparam int ADDR_W  = 17;
  localparam int FULL_W  = 640;
  localparam int SHORT_W = 8;
  localparam int HB_LEN  = 16;
  localparam int N_VEC   = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  logic [9:0]        hcount = '0;
  logic [9:0]        vcount = '0;
  logic              hsync  = 1'b1;
  logic              vsync  = 1'b1;
  logic              hblank = 1'b1;
  logic              vblank = 1'b1;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd_en;
  logic [7:0]        fb_data;
  logic [3:0]        vga_r, vga_g, vga_b;
  logic              vga_hsync, vga_vsync, vblank_start;

  vga_pixel_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .hcount       (hcount),
    .vcount       (vcount),
    .hsync        (hsync),
    .vsync        (vsync),
    .hblank       (hblank),
    .vblank       (vblank),
    .fb_addr      (fb_addr),
    .fb_rd_en     (fb_rd_en),
    .fb_data      (fb_data),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync),
    .vblank_start (vblank_start)
  );

  // synchronous RAM model, one cycle read latency
  logic [7:0] mem [0:76799];
  always @(posedge clk) fb_data <= (fb_addr < 17'd76800) ? mem[fb_addr] : 8'h00;

  typedef struct {
    int x; int y; bit hb; bit vb; bit hs; bit vs;
  } pix_t;

  typedef struct {
    int x; int y; logic [3:0] r; logic [3:0] g; logic [3:0] b;
  } vec_t;

  pix_t hist [0:2];  // [0]=last driven input, [2]=input three cycles ago
  vec_t vecs [N_VEC];
  int   vec_hits [N_VEC];

  int checks = 0;
  int errors = 0;
  int mode = 0;           // 2: full checks, 3: output must be black
  bit vec_en = 1'b0;
  int cyc = 0;
  int hs_fall_in = -1000;
  int vbs_count = 0;
  int pulse_y = -1;
  bit rst_next = 1'b0;
  bit prev_in_hs = 1'b1;
  bit prev_vga_hs = 1'b1;
  logic [31:0] last_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int x, input int y);
    return 32'((y / 2) * 320 + x / 2);
  endfunction

  task automatic full_checks();
    pix_t h1, h2, h3;
    bit   act1;
    h1 = hist[0];
    h2 = hist[1];
    h3 = hist[2];
    act1 = !h1.hb && !h1.vb;
    check("rd_en", {31'd0, fb_rd_en}, {31'd0, act1});
    if (act1) check("addr", fb_addr, exp_addr(h1.x, h1.y));
    else if (!h1.vb) check("addr_hold", fb_addr, last_exp);
    if (act1 && h1.x == 639 && h1.y == 479) check("last_addr", fb_addr, 32'd76799);
    if (act1 && h1.x == 0 && h1.y == 2) check("line2_first", fb_addr, 32'd320);
    check("hsync_align", {31'd0, vga_hsync}, {31'd0, h3.hs});
    check("vsync_align", {31'd0, vga_vsync}, {31'd0, h3.vs});
    if (h3.hb || h3.vb) check("blank_rgb", {vga_r, vga_g, vga_b}, 32'h0);
    if (vec_en && !h3.hb && !h3.vb) begin
      for (int i = 0; i < N_VEC; i++) begin
        if (h3.x == vecs[i].x && h3.y == vecs[i].y) begin
          vec_hits[i]++;
          check("rgb_vec", {vga_r, vga_g, vga_b}, {vecs[i].r, vecs[i].g, vecs[i].b});
        end
      end
    end
    check("vblank_start", {31'd0, vblank_start}, {31'd0, h1.vb && !h2.vb});
    if (vblank_start) vbs_count++;
    if (prev_vga_hs && !vga_hsync) check("hsync_latency", 32'(cyc - hs_fall_in), 32'd3);
  endtask

  // driver: check what the previous edges produced, then present the next pixel
  task automatic step(input int x, input int y, input bit hb, input bit vb,
                      input bit hs, input bit vs, input bit rst_v);
    @(negedge clk);
    cyc++;
    if (!rst) begin
      check("reset_outs", {vga_hsync, vga_vsync, vga_r, vga_g, vga_b, fb_rd_en},
            {1'b1, 1'b1, 12'h000, 1'b0});
      check("reset_addr", fb_addr, 32'd0);
    end else if (mode == 3) begin
      check("black", {vga_r, vga_g, vga_b}, 32'h0);
    end else if (mode == 2) begin
      full_checks();
    end
    prev_vga_hs = vga_hsync;
    if (!rst) last_exp = '0;
    else if (!hist[0].hb && !hist[0].vb) last_exp = exp_addr(hist[0].x, hist[0].y);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '{x: x, y: y, hb: hb, vb: vb, hs: hs, vs: vs};
    if (prev_in_hs && !hs) hs_fall_in = cyc;
    prev_in_hs = hs;
    hcount = 10'(x);
    vcount = 10'(y);
    hblank = hb;
    vblank = vb;
    hsync  = hs;
    vsync  = vs;
    rst    = rst_v;
  endtask

  task automatic run_line(input int y);
    int w;
    w = (y <= 3 || y == 478 || y == 479) ? FULL_W : SHORT_W;
    for (int x = 0; x < w + HB_LEN; x++) begin
      bit pulse;
      pulse = (y == pulse_y) && (x >= 2) && (x < 5);
      step(x, y, x >= w, y >= 480, !((x >= w + 4) && (x < w + 8)),
           !(y == 481 || y == 482), rst_next && !pulse);
    end
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{x: 0,   y: 0,   r: 4'hF, g: 4'hF, b: 4'hF};
    vecs[1]  = '{x: 1,   y: 0,   r: 4'hF, g: 4'hF, b: 4'hF};
    vecs[2]  = '{x: 2,   y: 0,   r: 4'h0, g: 4'h0, b: 4'h5};
    vecs[3]  = '{x: 6,   y: 0,   r: 4'h0, g: 4'h0, b: 4'hF};
    vecs[4]  = '{x: 20,  y: 0,   r: 4'h0, g: 4'h4, b: 4'hA};
    vecs[5]  = '{x: 56,  y: 0,   r: 4'h0, g: 4'hF, b: 4'h0};
    vecs[6]  = '{x: 448, y: 0,   r: 4'hF, g: 4'h0, b: 4'h0};
    vecs[7]  = '{x: 258, y: 1,   r: 4'h9, g: 4'h0, b: 4'h5};
    vecs[8]  = '{x: 0,   y: 2,   r: 4'h4, g: 4'h0, b: 4'h0};
    vecs[9]  = '{x: 639, y: 479, r: 4'hF, g: 4'hF, b: 4'hF};
    vecs[10] = '{x: 636, y: 3,   r: 4'h6, g: 4'hF, b: 4'hA};
    vecs[11] = '{x: 100, y: 478, r: 4'hF, g: 4'h9, b: 4'hA};
    for (int i = 0; i < N_VEC; i++) vec_hits[i] = 0;
    for (int i = 0; i < 76800; i++) mem[i] = 8'(i);
    mem[0] = 8'hFF;
    for (int i = 0; i < 3; i++) hist[i] = '{x: 0, y: 0, hb: 1, vb: 1, hs: 1, vs: 1};

    #1 rst = 1'b0;

    // sync generator free-running under reset, released during vblank
    rst_next = 1'b0;
    for (int y = 476; y < 482; y++) run_line(y);
    mode = 3;
    rst_next = 1'b1;
    for (int y = 482; y < 485; y++) run_line(y);

    // frame A: first full frame after release
    mode = 2;
    vec_en = 1'b1;
    vbs_count = 0;
    for (int y = 0; y < 485; y++) run_line(y);
    check("vbs_per_frame_a", 32'(vbs_count), 32'd1);

    // frame B: reset pulse on line 200, black until the next vblank
    vec_en = 1'b0;
    for (int y = 0; y < 200; y++) run_line(y);
    mode = 3;
    pulse_y = 200;
    for (int y = 200; y < 485; y++) run_line(y);
    pulse_y = -1;

    // frame C: must match frame A
    mode = 2;
    vec_en = 1'b1;
    vbs_count = 0;
    for (int y = 0; y < 485; y++) run_line(y);
    check("vbs_per_frame_c", 32'(vbs_count), 32'd1);

    for (int i = 0; i < N_VEC; i++) check("vec_hits", 32'(vec_hits[i]), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
